// File: rtl/slice_update_engine.sv
// Queued indexed-part-select update engine for a wide state vector.
// Latency: a command pushed into an empty queue is applied on the next rising edge.
// Backpressure: cmd_ready drops only when the queue is full; hold stalls application.

// Generic synchronous FIFO; push ignored when full, pop ignored when empty.
// Latency: an entry written at edge E is visible at pop_dat_o after E.
// Backpressure: full_o reflects occupancy only, with no same-cycle pop credit.
module generic_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o    = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // Entry storage: payload needs no reset, only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module slice_update_engine #(
  parameter int WIDTH = 128,
  parameter int SLICE = 3,
  parameter int IDXW  = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDXW-1:0]  cmd_index,
  input  logic [SLICE-1:0] cmd_data,
  input  logic             hold,
  output logic [WIDTH-1:0] vec_q,
  output logic             busy,
  output logic [15:0]      oob_count,
  output logic [15:0]      apply_cnt
);
  localparam int VW = $clog2(WIDTH);

  localparam logic [1:0] OP_ASC = 2'b00;
  localparam logic [1:0] OP_DSC = 2'b01;
  localparam logic [1:0] OP_TGL = 2'b10;

  typedef struct packed {
    logic [1:0]       op;
    logic [IDXW-1:0]  index;
    logic [SLICE-1:0] data;
  } cmd_t;

  cmd_t             in_dat, hd_dat;
  logic             fifo_full, fifo_empty;
  logic             pop;
  logic [WIDTH-1:0] vec_d;
  logic             drop_d;
  logic [15:0]      oob_q, apply_q;
  int               base, t;

  assign in_dat    = '{op: cmd_op, index: cmd_index, data: cmd_data};
  assign cmd_ready = ~fifo_full;
  assign busy      = ~fifo_empty;
  assign pop       = ~fifo_empty & ~hold;
  assign oob_count = oob_q;
  assign apply_cnt = apply_q;

  generic_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk        (clk),
    .reset_l    (reset_l),
    .push_i     (cmd_valid),
    .push_dat_i (in_dat),
    .pop_i      (pop),
    .pop_dat_o  (hd_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Next vector value for the head command, clipping every target outside the vector.
  always_comb begin
    vec_d  = vec_q;
    drop_d = 1'b0;
    base   = int'(hd_dat.index);
    t      = 0;
    case (hd_dat.op)
      OP_ASC: begin
        for (int k = 0; k < SLICE; k++) begin
          t = base + k;
          if (t < WIDTH) vec_d[t[VW-1:0]] = hd_dat.data[k];
          else           drop_d = 1'b1;
        end
      end
      OP_DSC: begin
        // Lowest target sits SLICE-1 below the base; it may go negative.
        for (int k = 0; k < SLICE; k++) begin
          t = base - SLICE + 1 + k;
          if (t >= 0 && t < WIDTH) vec_d[t[VW-1:0]] = hd_dat.data[k];
          else                     drop_d = 1'b1;
        end
      end
      OP_TGL: begin
        if (base < WIDTH) vec_d[base[VW-1:0]] = ~vec_q[base[VW-1:0]];
        else              drop_d = 1'b1;
      end
      default: vec_d = '0;
    endcase
  end

  // Commit the head command and update the clip and apply counters.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      vec_q   <= '0;
      oob_q   <= '0;
      apply_q <= '0;
    end else if (pop) begin
      vec_q   <= vec_d;
      apply_q <= apply_q + 16'd1;
      if (drop_d && oob_q != 16'hFFFF) oob_q <= oob_q + 16'd1;
    end
  end
endmodule
